updown_tracker: RTL and testbench

Sequence decoder for the up/down counter's 5-bit count bus. The block samples the count on each valid cycle and recovers the counting direction. It reports wrap-around and reset/preset loads as one-cycle pulses and flags sequences the counter cannot legally produce. It sits on the consumer side of the counter, feeding status logic and the verification monitor.

---
 rtl/updown_tracker.sv | 178 +++++++++++++++++
 tb/tb_updown_tracker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_tracker.sv
// Decodes the up/down counter's count bus into direction, wrap and load events, and flags illegal sequences.
// Optional stall detection is enabled by defining UPDOWN_TRACKER_HOLD_ERR_EN.
module updown_tracker #(
    parameter int WIDTH      = 5,
    parameter int HOLD_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clear,
    output logic             dir,
    output logic             dir_valid,
    output logic             wrap,
    output logic [1:0]       load_det,
    output logic [7:0]       step_cnt,
    output logic             err
);

`ifdef UPDOWN_TRACKER_HOLD_ERR_EN
    localparam bit HOLD_ERR_EN = 1'b1;
`else
    localparam bit HOLD_ERR_EN = 1'b0;
`endif

    localparam int HW = (HOLD_LIMIT < 2) ? 1 : $clog2(HOLD_LIMIT + 1);

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_SYNC,
        ST_UP,
        ST_DOWN,
        ST_FAULT
    } state_t;

    typedef enum logic [2:0] {
        CL_UP,
        CL_DOWN,
        CL_HOLD,
        CL_RLOAD,
        CL_PLOAD,
        CL_ILLEGAL
    } class_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] prev_reg, prev_next;
    logic [7:0]       step_reg, step_next;
    logic             wrap_reg, wrap_next;
    logic [1:0]       load_reg, load_next;
    logic [HW-1:0]    hold_reg, hold_next;

    logic [WIDTH-1:0] delta;
    class_t           cls;
    logic [7:0]       step_inc;
    logic [HW-1:0]    hold_inc;

    // Step moves win over loads, so 1->0 is a down step and 30->31 an up step.
    always_comb begin
        delta = count_in - prev_reg;
        if (delta == WIDTH'(1))
            cls = CL_UP;
        else if (delta == '1)
            cls = CL_DOWN;
        else if (delta == '0)
            cls = CL_HOLD;
        else if (count_in == '0)
            cls = CL_RLOAD;
        else if (count_in == '1)
            cls = CL_PLOAD;
        else
            cls = CL_ILLEGAL;
    end

    assign step_inc = (step_reg == 8'hFF) ? 8'hFF : step_reg + 8'd1;
    assign hold_inc = hold_reg + HW'(1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_EMPTY;
            prev_reg  <= '0;
            step_reg  <= '0;
            wrap_reg  <= 1'b0;
            load_reg  <= 2'b00;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            prev_reg  <= prev_next;
            step_reg  <= step_next;
            wrap_reg  <= wrap_next;
            load_reg  <= load_next;
            hold_reg  <= hold_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        step_next  = step_reg;
        wrap_next  = 1'b0;
        load_next  = 2'b00;
        hold_next  = hold_reg;

        if (clear) begin
            // A sample on the clear cycle is dropped, prev included.
            state_next = ST_EMPTY;
            step_next  = '0;
            hold_next  = '0;
        end else if (sample_valid) begin
            prev_next = count_in;
            case (state_reg)
                ST_EMPTY: begin
                    state_next = ST_SYNC;
                    step_next  = '0;
                    hold_next  = '0;
                end
                ST_SYNC, ST_UP, ST_DOWN: begin
                    hold_next = '0;
                    case (cls)
                        CL_UP: begin
                            state_next = ST_UP;
                            step_next  = (state_reg == ST_UP) ? step_inc : 8'd1;
                            wrap_next  = (count_in == '0);
                        end
                        CL_DOWN: begin
                            state_next = ST_DOWN;
                            step_next  = (state_reg == ST_DOWN) ? step_inc : 8'd1;
                            wrap_next  = (count_in == '1);
                        end
                        CL_HOLD: begin
                            if (HOLD_ERR_EN && (state_reg != ST_SYNC)) begin
                                if (hold_inc == HW'(HOLD_LIMIT)) begin
                                    state_next = ST_FAULT;
                                    step_next  = '0;
                                end else begin
                                    hold_next = hold_inc;
                                end
                            end
                        end
                        CL_RLOAD: begin
                            state_next = ST_SYNC;
                            step_next  = '0;
                            load_next  = 2'b01;
                        end
                        CL_PLOAD: begin
                            state_next = ST_SYNC;
                            step_next  = '0;
                            load_next  = 2'b10;
                        end
                        default: begin
                            state_next = ST_FAULT;
                            step_next  = '0;
                        end
                    endcase
                end
                ST_FAULT: begin
                end
                default: begin
                    state_next = ST_EMPTY;
                    step_next  = '0;
                    hold_next  = '0;
                end
            endcase
        end
    end

    // Output decode from registered state
    always_comb begin
        dir       = (state_reg == ST_UP);
        dir_valid = (state_reg == ST_UP) || (state_reg == ST_DOWN);
        err       = (state_reg == ST_FAULT);
        wrap      = wrap_reg;
        load_det  = load_reg;
        step_cnt  = step_reg;
    end

endmodule

// File: tb/tb_updown_tracker.sv
// Scoreboard bench for updown_tracker: directed sequences plus randomized samples against a behavioural model.
`timescale 1ns/1ps
module tb_updown_tracker;
    localparam int WIDTH      = 5;
    localparam int HOLD_LIMIT = 4;
    localparam int MODV       = 1 << WIDTH;
    localparam int MAXV       = MODV - 1;

`ifdef UPDOWN_TRACKER_HOLD_ERR_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    localparam int M_EMPTY = 0, M_SYNC = 1, M_UP = 2, M_DOWN = 3, M_FAULT = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             sample_valid = 1'b0;
    logic [WIDTH-1:0] count_in = '0;
    logic             clear = 1'b0;
    logic             dir, dir_valid, wrap, err;
    logic [1:0]       load_det;
    logic [7:0]       step_cnt;

    updown_tracker #(.WIDTH(WIDTH), .HOLD_LIMIT(HOLD_LIMIT)) dut (
        .clk(clk),
        .reset(reset),
        .sample_valid(sample_valid),
        .count_in(count_in),
        .clear(clear),
        .dir(dir),
        .dir_valid(dir_valid),
        .wrap(wrap),
        .load_det(load_det),
        .step_cnt(step_cnt),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dir;
        int dv;
        int wrap;
        int load;
        int step;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    int m_mode = M_EMPTY;
    int m_prev = 0;
    int m_steps = 0;
    int m_holds = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Behavioural model: what the decoder should report after the coming edge.
    task automatic model_apply(input bit v, input int c, input bit clr);
        exp_t e;
        int   d;
        e.wrap = 0;
        e.load = 0;
        if (clr) begin
            m_mode = M_EMPTY; m_steps = 0; m_holds = 0;
        end else if (v) begin
            d = (c - m_prev + MODV) % MODV;
            if (m_mode == M_EMPTY) begin
                m_mode = M_SYNC; m_steps = 0; m_holds = 0;
            end else if (m_mode != M_FAULT) begin
                if (d == 1) begin
                    m_steps = (m_mode == M_UP) ? ((m_steps < 255) ? m_steps + 1 : 255) : 1;
                    m_mode = M_UP; e.wrap = (c == 0); m_holds = 0;
                end else if (d == MAXV) begin
                    m_steps = (m_mode == M_DOWN) ? ((m_steps < 255) ? m_steps + 1 : 255) : 1;
                    m_mode = M_DOWN; e.wrap = (c == MAXV); m_holds = 0;
                end else if (d == 0) begin
                    if (HOLD_EN && m_mode != M_SYNC) begin
                        m_holds++;
                        if (m_holds >= HOLD_LIMIT) begin
                            m_mode = M_FAULT; m_steps = 0; m_holds = 0;
                        end
                    end
                end else if (c == 0) begin
                    e.load = 1; m_mode = M_SYNC; m_steps = 0; m_holds = 0;
                end else if (c == MAXV) begin
                    e.load = 2; m_mode = M_SYNC; m_steps = 0; m_holds = 0;
                end else begin
                    m_mode = M_FAULT; m_steps = 0; m_holds = 0;
                end
            end
            m_prev = c;
        end
        e.dir  = (m_mode == M_UP);
        e.dv   = (m_mode == M_UP || m_mode == M_DOWN);
        e.step = m_steps;
        e.err  = (m_mode == M_FAULT);
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit v, input int c, input bit clr);
        @(negedge clk);
        sample_valid = v;
        count_in     = WIDTH'(c);
        clear        = clr;
        model_apply(v, c, clr);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_dv"}, dir_valid, 0);
        chk({tag, "_wrap"}, wrap, 0);
        chk({tag, "_load"}, load_det, 0);
        chk({tag, "_step"}, step_cnt, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        sample_valid = 1'b0;
        clear        = 1'b0;
        reset        = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_mode = M_EMPTY; m_prev = 0; m_steps = 0; m_holds = 0;
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        @(negedge clk);
        reset = 1'b1;
        $display("txn reset applied and released at t=%0t", $time);
    endtask

    // Monitor: one registered result per driven cycle, popped after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                chk("dir", dir, e.dir);
                chk("dir_valid", dir_valid, e.dv);
                chk("wrap", wrap, e.wrap);
                chk("load_det", load_det, e.load);
                chk("step_cnt", step_cnt, e.step);
                chk("err", err, e.err);
                $display("txn %0d: dir=%0d dv=%0d wrap=%0d load=%0d step=%0d err=%0d",
                         txn, dir, dir_valid, wrap, load_det, step_cnt, err);
            end
        end
    end

    initial begin
        int seq1[]  = '{3, 4, 5, 6};
        int seq2[]  = '{30, 31, 0, 1};
        int seq3[]  = '{2, 1, 0, 31, 5, 9};
        int seq4[]  = '{8, 9, 10, 31, 0, 1};
        int seq5[]  = '{7, 8, 9, 8, 7};
        int seq6[]  = '{11, 12, 12, 12, 12, 12, 13};
        int r, c, wait_cnt;

        #12;
        check_all_zero("por");
        @(negedge clk);
        reset = 1'b1;

        foreach (seq1[i]) drive(1, seq1[i], 0);
        drive(0, 0, 0);
        drive(1, 7, 0);
        drive(1, 0, 1);
        foreach (seq2[i]) drive(1, seq2[i], 0);
        drive(1, 0, 1);
        foreach (seq3[i]) drive(1, seq3[i], 0);
        drive(0, 0, 1);
        foreach (seq4[i]) drive(1, seq4[i], 0);
        drive(0, 0, 1);
        foreach (seq5[i]) drive(1, seq5[i], 0);
        mid_reset();
        foreach (seq6[i]) drive(1, seq6[i], 0);
        drive(0, 0, 1);
        // Long up run to reach step_cnt saturation.
        for (int i = 0; i < 270; i++) drive(1, (i + 3) % MODV, 0);
        drive(0, 0, 1);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      c = (m_prev + 1) % MODV;
            else if (r < 60) c = (m_prev + MAXV) % MODV;
            else if (r < 70) c = m_prev;
            else if (r < 76) c = 0;
            else if (r < 82) c = MAXV;
            else             c = $urandom_range(0, MAXV);
            if ($urandom_range(0, 999) < 3)
                mid_reset();
            else
                drive($urandom_range(0, 99) < 85, c, $urandom_range(0, 99) < 2);
        end

        @(negedge clk);
        sample_valid = 1'b0;
        clear        = 1'b0;
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
